wb_stage: RTL and testbench

Parametrised writeback stage for the five-stage MIPS pipeline: an M→W pipeline register with stall and flush, sub-word load extension, a four-source write-data mux, $0 write suppression and an instruction-retire counter. It sits between the Memory stage and the register file and drives the GRF write port and the W-stage forwarding sources.

---
 rtl/wb_stage.sv | 153 +++++++++++++++
 tb/tb_wb_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: M->W pipeline register with stall/flush, sub-word load
// extension, write-data select, $0 write suppression and a retire counter.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              valid_M_i,
  input  logic [31:0]       pc_M_i,
  input  logic [DATA_W-1:0] mem_rdata_M_i,
  input  logic [DATA_W-1:0] alu_M_i,
  input  logic [DATA_W-1:0] hilo_M_i,
  input  logic              regWrite_M_i,
  input  logic [REG_AW-1:0] a3_M_i,
  input  logic [1:0]        wdsel_M_i,
  input  logic [2:0]        ld_type_M_i,
  input  logic [1:0]        addr_lo_M_i,
  output logic              regWrite_D_o,
  output logic [REG_AW-1:0] a3_D_o,
  output logic [DATA_W-1:0] wd_D_o,
  output logic [31:0]       pc_W_o,
  output logic              valid_W_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  typedef enum logic [1:0] {
    WD_MEM  = 2'd0,
    WD_ALU  = 2'd1,
    WD_LINK = 2'd2,
    WD_HILO = 2'd3
  } wdsel_e;

  // Codes 5..7 are not listed and fall through to the full-word path.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  logic              valid_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] hilo_q;
  logic              regwrite_q;
  logic [REG_AW-1:0] a3_q;
  wdsel_e            wdsel_q;
  logic [2:0]        ld_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] link_ext;

  // W pipeline register: reset and flush both load an all-zero bubble,
  // flush taking effect even while stalled.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
      hilo_q     <= '0;
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      wdsel_q    <= WD_MEM;
      ld_q       <= '0;
      addr_lo_q  <= '0;
    end else if (en_i) begin
      valid_q    <= valid_M_i;
      pc_q       <= pc_M_i;
      rdata_q    <= mem_rdata_M_i;
      alu_q      <= alu_M_i;
      hilo_q     <= hilo_M_i;
      regwrite_q <= regWrite_M_i;
      a3_q       <= a3_M_i;
      wdsel_q    <= wdsel_e'(wdsel_M_i);
      ld_q       <= ld_type_M_i;
      addr_lo_q  <= addr_lo_M_i;
    end
  end

  // Retire counter: counts instructions actually accepted into W.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!flush_i && en_i && valid_M_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sub-word load extension on the low 32 bits of the registered read data.
  always_comb begin
    byte_v = 8'h00;
    case (addr_lo_q)
      2'd0: byte_v = rdata_q[7:0];
      2'd1: byte_v = rdata_q[15:8];
      2'd2: byte_v = rdata_q[23:16];
      2'd3: byte_v = rdata_q[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_ext = rdata_q;
    case (ld_q)
      LD_B: begin
        ld_ext       = {DATA_W{byte_v[7]}};
        ld_ext[7:0]  = byte_v;
      end
      LD_BU: begin
        ld_ext       = '0;
        ld_ext[7:0]  = byte_v;
      end
      LD_H: begin
        ld_ext       = {DATA_W{half_v[15]}};
        ld_ext[15:0] = half_v;
      end
      LD_HU: begin
        ld_ext       = '0;
        ld_ext[15:0] = half_v;
      end
      default: ld_ext = rdata_q;
    endcase
  end

  // Write-data select; the link address wraps at 32 bits and is zero-extended.
  always_comb begin
    link_ext       = '0;
    link_ext[31:0] = pc_q + 32'd8;
    wd_D_o         = ld_ext;
    case (wdsel_q)
      WD_MEM:  wd_D_o = ld_ext;
      WD_ALU:  wd_D_o = alu_q;
      WD_LINK: wd_D_o = link_ext;
      WD_HILO: wd_D_o = hilo_q;
      default: wd_D_o = ld_ext;
    endcase
  end

  assign regWrite_D_o = regwrite_q & valid_q & (a3_q != '0);
  assign a3_D_o       = a3_q;
  assign pc_W_o       = pc_q;
  assign valid_W_o    = valid_q;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (32-bit datapath, 3-bit retire counter).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_i;
  logic        flush_i;
  logic        valid_M_i;
  logic [31:0] pc_M_i;
  logic [31:0] mem_rdata_M_i;
  logic [31:0] alu_M_i;
  logic [31:0] hilo_M_i;
  logic        regWrite_M_i;
  logic [4:0]  a3_M_i;
  logic [1:0]  wdsel_M_i;
  logic [2:0]  ld_type_M_i;
  logic [1:0]  addr_lo_M_i;
  logic        regWrite_D_o;
  logic [4:0]  a3_D_o;
  logic [31:0] wd_D_o;
  logic [31:0] pc_W_o;
  logic        valid_W_o;
  logic [2:0]  retire_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [2:0]  exp_cnt = 3'd0;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i),
    .valid_M_i(valid_M_i), .pc_M_i(pc_M_i), .mem_rdata_M_i(mem_rdata_M_i),
    .alu_M_i(alu_M_i), .hilo_M_i(hilo_M_i), .regWrite_M_i(regWrite_M_i),
    .a3_M_i(a3_M_i), .wdsel_M_i(wdsel_M_i), .ld_type_M_i(ld_type_M_i),
    .addr_lo_M_i(addr_lo_M_i), .regWrite_D_o(regWrite_D_o), .a3_D_o(a3_D_o),
    .wd_D_o(wd_D_o), .pc_W_o(pc_W_o), .valid_W_o(valid_W_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_m(input logic v, input logic [31:0] pc, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [31:0] hl, input logic rw,
                       input logic [4:0] a3, input logic [1:0] ws, input logic [2:0] ld,
                       input logic [1:0] al);
    valid_M_i = v;  pc_M_i = pc;  mem_rdata_M_i = rd;  alu_M_i = alu;
    hilo_M_i = hl;  regWrite_M_i = rw;  a3_M_i = a3;  wdsel_M_i = ws;
    ld_type_M_i = ld;  addr_lo_M_i = al;
  endtask

  // One clock; tracks the expected retire count and samples 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    if (reset) exp_cnt = 3'd0;
    else if (!flush_i && en_i && valid_M_i) exp_cnt = exp_cnt + 3'd1;
    #1;
  endtask

  task automatic ld_case(input logic [2:0] ld, input logic [1:0] al,
                         input logic [31:0] rd, input logic [31:0] exp);
    set_m(1'b1, 32'h0000_1000, rd, 32'h0, 32'h0, 1'b1, 5'd8, 2'd0, ld, al);
    tick;
    check($sformatf("ld%0d_a%0d_wd", ld, al), wd_D_o, exp);
    check("ld_cnt", retire_cnt_o, exp_cnt);
  endtask

  logic [1:0] seq [15];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with live-looking M inputs
    reset = 1'b1; en_i = 1'b1; flush_i = 1'b0;
    set_m(1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 5'($urandom_range(1, 31)),
          2'($urandom), 3'($urandom), 2'($urandom));
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rst_rw", regWrite_D_o, 1'b0);
      check("rst_a3", a3_D_o, 5'd0);
      check("rst_wd", wd_D_o, 32'h0);
      check("rst_pc", pc_W_o, 32'h0);
      check("rst_valid", valid_W_o, 1'b0);
      check("rst_cnt", retire_cnt_o, 3'd0);
    end
    reset = 1'b0;
    set_m(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0);
    tick;
    check("post_rst_cnt", retire_cnt_o, 3'd0);
    check("post_rst_valid", valid_W_o, 1'b0);

    // 2. Load extension
    set_m(1'b1, 32'h0000_1000, 32'h1280_3456, 32'h0, 32'h0, 1'b1, 5'd8, 2'd0, 3'd1, 2'd2);
    tick;
    check("lb_wd", wd_D_o, 32'hFFFF_FF80);
    check("lb_rw", regWrite_D_o, 1'b1);
    check("lb_a3", a3_D_o, 5'd8);
    check("lb_pc", pc_W_o, 32'h0000_1000);
    check("lb_valid", valid_W_o, 1'b1);
    check("lb_cnt", retire_cnt_o, 3'd1);
    ld_case(3'd4, 2'd2, 32'h1280_3456, 32'h0000_1280);
    ld_case(3'd1, 2'd0, 32'h1280_3456, 32'h0000_0056);
    ld_case(3'd1, 2'd1, 32'h1280_3456, 32'h0000_0034);
    ld_case(3'd2, 2'd2, 32'h1280_3456, 32'h0000_0080);
    ld_case(3'd3, 2'd0, 32'h1280_3456, 32'h0000_3456);
    ld_case(3'd3, 2'd3, 32'h1280_3456, 32'h0000_1280);
    ld_case(3'd0, 2'd1, 32'h1280_3456, 32'h1280_3456);
    ld_case(3'd6, 2'd1, 32'h1280_3456, 32'h1280_3456);
    ld_case(3'd3, 2'd2, 32'h8000_1234, 32'hFFFF_8000);
    ld_case(3'd4, 2'd0, 32'h0000_FFFE, 32'h0000_FFFE);
    ld_case(3'd1, 2'd3, 32'h9A00_0000, 32'hFFFF_FF9A);

    // 3. Link, HI/LO, $0 and invalid suppression
    set_m(1'b1, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0);
    tick;
    check("link_wd", wd_D_o, 32'h0000_3008);
    check("link_pc", pc_W_o, 32'h0000_3000);
    check("link_rw", regWrite_D_o, 1'b1);
    check("link_a3", a3_D_o, 5'd31);
    set_m(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0);
    tick;
    check("link_wrap_wd", wd_D_o, 32'h0000_0004);
    set_m(1'b1, 32'h0000_3010, 32'h0, 32'h0000_0055, 32'h0, 1'b1, 5'd0, 2'd1, 3'd0, 2'd0);
    tick;
    check("r0_rw", regWrite_D_o, 1'b0);
    check("r0_wd", wd_D_o, 32'h0000_0055);
    check("r0_a3", a3_D_o, 5'd0);
    set_m(1'b1, 32'h0000_3014, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd2, 2'd3, 3'd0, 2'd0);
    tick;
    check("hilo_wd", wd_D_o, 32'hDEAD_BEEF);
    check("hilo_rw", regWrite_D_o, 1'b1);
    set_m(1'b0, 32'h0000_3018, 32'h0, 32'h0000_0066, 32'h0, 1'b1, 5'd5, 2'd1, 3'd0, 2'd0);
    tick;
    check("inv_rw", regWrite_D_o, 1'b0);
    check("inv_valid", valid_W_o, 1'b0);
    check("inv_cnt", retire_cnt_o, exp_cnt);
    set_m(1'b1, 32'h0000_301C, 32'h0, 32'h0000_0077, 32'h0, 1'b0, 5'd7, 2'd1, 3'd0, 2'd0);
    tick;
    check("norw_rw", regWrite_D_o, 1'b0);

    // 4. Stall then flush
    set_m(1'b1, 32'h0000_4000, 32'h0, 32'hA5A5_0001, 32'h0, 1'b1, 5'd9, 2'd1, 3'd0, 2'd0);
    tick;
    check("A_wd", wd_D_o, 32'hA5A5_0001);
    en_i = 1'b0;
    set_m(1'b1, 32'h0000_5000, 32'h0, 32'h0000_0011, 32'h0, 1'b1, 5'd10, 2'd1, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_wd", wd_D_o, 32'hA5A5_0001);
      check("stall_a3", a3_D_o, 5'd9);
      check("stall_pc", pc_W_o, 32'h0000_4000);
      check("stall_rw", regWrite_D_o, 1'b1);
      check("stall_cnt", retire_cnt_o, exp_cnt);
    end
    flush_i = 1'b1;
    tick;
    check("flush_valid", valid_W_o, 1'b0);
    check("flush_rw", regWrite_D_o, 1'b0);
    check("flush_wd", wd_D_o, 32'h0);
    check("flush_pc", pc_W_o, 32'h0);
    en_i = 1'b1;
    tick;
    check("flush_en_valid", valid_W_o, 1'b0);
    check("flush_en_cnt", retire_cnt_o, exp_cnt);
    flush_i = 1'b0;

    // 5. Counter wrap: 0=valid, 1=invalid, 2=stall (9 valid, 4 invalid, 2 stall)
    reset = 1'b1;
    tick;
    reset = 1'b0;
    seq = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1,
            2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
    foreach (seq[i]) begin
      en_i = (seq[i] != 2'd2);
      set_m(seq[i] != 2'd1, 32'h0000_6000 + 32'(i) * 32'd4, 32'h0, 32'h0, 32'h0,
            1'b1, 5'd3, 2'd1, 3'd0, 2'd0);
      tick;
      check("wrap_step_cnt", retire_cnt_o, exp_cnt);
    end
    check("wrap_final_cnt", retire_cnt_o, 3'd1);
    en_i = 1'b1;

    // 6. Reset while a write sits in W
    set_m(1'b1, 32'h0000_7000, 32'h0, 32'h0000_0099, 32'h0, 1'b1, 5'd5, 2'd1, 3'd0, 2'd0);
    tick;
    check("mid_pre_rw", regWrite_D_o, 1'b1);
    reset = 1'b1;
    set_m(1'b1, 32'h0000_7004, 32'h0, 32'h0000_00AA, 32'h0, 1'b1, 5'd6, 2'd1, 3'd0, 2'd0);
    tick;
    check("mid_rst_rw", regWrite_D_o, 1'b0);
    check("mid_rst_cnt", retire_cnt_o, 3'd0);
    check("mid_rst_a3", a3_D_o, 5'd0);
    check("mid_rst_wd", wd_D_o, 32'h0);
    reset = 1'b0;
    en_i = 1'b0;
    tick;
    check("mid_after_rw", regWrite_D_o, 1'b0);
    check("mid_after_valid", valid_W_o, 1'b0);
    check("mid_after_cnt", retire_cnt_o, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
